// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory request/response, redirect strobe and decode-side queue head.
// The master modport is the fetch unit; the slave modport is memory plus decode.
interface instr_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc,
    input  imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc,
    output imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, instr_ready
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: single-outstanding fetch FSM feeding a QDEPTH-entry instruction queue.
// Redirects flush the queue and retarget fetch; a response already in flight is discarded.
//
// state  | meaning
// S_IDLE | queue (plus in-flight slot) full, waiting for space
// S_REQ  | imem_req asserted at r_req_addr, waiting for imem_gnt
// S_WAIT | request granted, waiting for imem_rvalid
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  instr_fetch_unit_if.master    bus
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] QD = CW'(QDEPTH);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t        r_state;
  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_req_addr;
  logic          r_imem_req;
  logic          r_discard;
  logic [31:0]   r_q_instr [QDEPTH];
  logic [31:0]   r_q_pc    [QDEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;

  logic          w_redirect;
  logic [31:0]   w_target;
  logic          w_rsp;
  logic          w_push;
  logic          w_pop;
  logic [CW-1:0] w_count_nxt;
  logic          w_unused_bits;

  assign w_redirect    = bus.redirect_valid;
  assign w_target      = {bus.redirect_pc[31:2], 2'b00};
  assign w_unused_bits = ^bus.redirect_pc[1:0];
  assign w_rsp         = (r_state == S_WAIT) && bus.imem_rvalid;
  assign w_push        = w_rsp && !r_discard && !w_redirect;
  assign w_pop         = (r_count != '0) && bus.instr_ready && !w_redirect;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + 1'b1;
      2'b01:   w_count_nxt = r_count - 1'b1;
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        r_q_instr[i] <= '0;
        r_q_pc[i]    <= '0;
      end
    end else if (w_redirect) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_q_instr[r_wr_ptr] <= bus.imem_rdata;
        r_q_pc[r_wr_ptr]    <= r_req_addr;
        r_wr_ptr            <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_fetch_pc <= RESET_PC;
      r_req_addr <= RESET_PC;
      r_imem_req <= 1'b0;
      r_discard  <= 1'b0;
    end else if (w_redirect) begin
      r_fetch_pc <= w_target;
      case (r_state)
        S_REQ: begin
          if (bus.imem_gnt) begin
            // granted in the redirect cycle: the reply is still coming and must be dropped
            r_state    <= S_WAIT;
            r_imem_req <= 1'b0;
            r_discard  <= 1'b1;
          end else begin
            r_req_addr <= w_target;
          end
        end
        S_WAIT: begin
          if (bus.imem_rvalid) begin
            r_state    <= S_REQ;
            r_imem_req <= 1'b1;
            r_req_addr <= w_target;
            r_discard  <= 1'b0;
          end else begin
            r_discard  <= 1'b1;
          end
        end
        default: begin
          r_state    <= S_REQ;
          r_imem_req <= 1'b1;
          r_req_addr <= w_target;
        end
      endcase
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_count < QD) begin
            r_state    <= S_REQ;
            r_imem_req <= 1'b1;
            r_req_addr <= r_fetch_pc;
          end
        end
        S_REQ: begin
          if (bus.imem_gnt) begin
            r_state    <= S_WAIT;
            r_imem_req <= 1'b0;
            r_fetch_pc <= r_fetch_pc + 32'd4;
          end
        end
        S_WAIT: begin
          if (bus.imem_rvalid) begin
            r_discard <= 1'b0;
            if (w_count_nxt < QD) begin
              r_state    <= S_REQ;
              r_imem_req <= 1'b1;
              r_req_addr <= r_fetch_pc;
            end else begin
              r_state    <= S_IDLE;
            end
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_imem_req <= 1'b0;
        end
      endcase
    end
  end

  assign bus.imem_req    = r_imem_req;
  assign bus.imem_addr   = r_req_addr;
  assign bus.instr_valid = (r_count != '0);
  assign bus.instr       = r_q_instr[r_rd_ptr];
  assign bus.instr_pc    = r_q_pc[r_rd_ptr];

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, fetch address loaded at reset.
REQ-002 Parameter: QDEPTH, 4, instruction queue depth in entries; power of two, 2 to 16.
REQ-003 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous, active-low.
REQ-005 Port: imem_req  output  1  fetch request to instruction memory.
REQ-006 Port: imem_addr  output  32  word-aligned fetch address.
REQ-007 Port: imem_gnt  input  1  memory accepts the request this cycle.
REQ-008 Port: imem_rvalid  input  1  read data valid.
REQ-009 Port: imem_rdata  input  32  instruction word.
REQ-010 Port: redirect_valid  input  1  branch/jump redirect strobe.
REQ-011 Port: redirect_pc  input  32  redirect target.
REQ-012 Port: instr_valid  output  1  queue head valid to the decode/control stage.
REQ-013 Port: instr  output  32  queue head instruction.
REQ-014 Port: instr_pc  output  32  address of the queue head instruction.
REQ-015 Port: instr_ready  input  1  decode stage consumes the head.

Function
REQ-016 Fetch FSM SHALL have states IDLE, REQ and WAIT, with at most one request outstanding.
REQ-017 IDLE->REQ SHALL occur when (queue count + outstanding) < QDEPTH, asserting imem_req with imem_addr = fetch_pc.
REQ-018 In REQ, imem_req and imem_addr SHALL hold stable until imem_gnt=1.
REQ-019 On grant, REQ->WAIT SHALL occur and fetch_pc SHALL advance by 4, mod 2^32 (32'hFFFF_FFFC wraps to 0).
REQ-020 In WAIT, imem_rvalid SHALL push {imem_rdata, issued address} into the queue, then go to REQ if space remains, else IDLE.
REQ-021 imem_rvalid outside WAIT SHALL be ignored.
REQ-022 instr_valid SHALL be 1 iff the queue is non-empty; instr and instr_pc SHALL show the head entry.
REQ-023 Pop SHALL occur when instr_valid & instr_ready; push and pop in the same cycle SHALL leave the count unchanged.
REQ-024 Queue overflow SHALL be impossible by the reservation rule in REQ-017; instr_ready with an empty queue SHALL have no effect.
REQ-025 Minimum latency SHALL be: imem_rvalid at cycle t gives instr_valid at t+1 with an empty queue.
REQ-026 redirect_valid SHALL have highest priority, and in its cycle SHALL:
- flush the queue (count 0);
- ignore any pop;
- load fetch_pc = {redirect_pc[31:2], 2'b00}.
REQ-027 On a redirect in REQ without imem_gnt, the request SHALL be abandoned and re-issued to the redirect target next cycle.
REQ-028 On a redirect in REQ with imem_gnt in the same cycle, the grant SHALL count as outstanding and its response SHALL be discarded.
REQ-029 On a redirect in WAIT, a discard flag SHALL set; the next imem_rvalid SHALL be dropped, clear the flag, and the FSM SHALL proceed to fetch the redirect target.
REQ-030 A redirect in the same cycle as a WAIT response SHALL drop that response.
REQ-031 Redirect at cycle N SHALL give imem_req=1, imem_addr=redirect target at N+1 when no response is pending.
REQ-032 Back-to-back redirects SHALL be honoured: the last one wins, and at most one discard SHALL be pending.

Reset
REQ-033 Asserting rst low SHALL, asynchronously:
- force FSM IDLE;
- set fetch_pc=RESET_PC;
- clear queue, count and discard flag;
- drive imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0.
REQ-034 Reset mid-transaction SHALL abandon the outstanding request; the first post-reset imem_req SHALL carry RESET_PC on the cycle after deassertion.

Verification
REQ-035 Reset release, memory with 1-cycle latency, instr_ready=1 -> imem_addr sequence 0,4,8,...; instr_pc matches, instr equals memory contents.
REQ-036 instr_ready=0 for 10 cycles -> exactly 4 entries fetched; imem_req stays 0 while full; no entry lost after ready returns.
REQ-037 Grant delayed 3 cycles -> imem_addr held constant through the stall; redirect_pc=32'h0000_0103 in WAIT -> stale response dropped, next instr_pc=32'h0000_0100.
REQ-038 fetch_pc=32'hFFFF_FFFC -> next request address 32'h0000_0000.
REQ-039 Redirect coincident with imem_gnt, and redirect coincident with a pop -> queue empty, one response discarded, next instr_pc = target.
REQ-040 rst low while in WAIT with 2 entries queued -> instr_valid=0 immediately; late imem_rvalid ignored; fetch restarts at RESET_PC.
